// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding request to instruction memory, a single
// registered instruction slot toward decode, and redirect handling that can drop a stale response.
module fetch_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_VALID = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic        imem_req_q;
   logic        if_valid_q;

   logic [31:0] redirect_tgt;
   logic        unused_redirect_lsbs;

   // Targets are word aligned; the two low bits are dropped unconditionally.
   assign redirect_tgt         = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      if_instr_d = if_instr_q;
      if_pc_d    = if_pc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_REQ;
            if (redirect) pc_d = redirect_tgt;
         end
         ST_REQ: begin
            if (imem_gnt) state_d = ST_WAIT;
            // A granted request that races a redirect still returns data; mark it for dropping.
            if (redirect) begin
               pc_d      = redirect_tgt;
               discard_d = imem_gnt;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               pc_d = redirect_tgt;
               if (imem_rvalid) begin
                  state_d   = ST_REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ST_REQ;
               end else begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = pc_q;
                  state_d    = ST_VALID;
               end
            end
         end
         ST_VALID: begin
            if (redirect) begin
               pc_d    = redirect_tgt;
               state_d = ST_REQ;
            end else if (!stall) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_REQ;
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // Request and valid are registered from the next state so they are glitch-free at the ports.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_BOOT;
         pc_q       <= RESET_VECTOR;
         discard_q  <= 1'b0;
         if_instr_q <= 32'h0;
         if_pc_q    <= 32'h0;
         imem_req_q <= 1'b0;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         discard_q  <= discard_d;
         if_instr_q <= if_instr_d;
         if_pc_q    <= if_pc_d;
         imem_req_q <= (state_d == ST_REQ);
         if_valid_q <= (state_d == ST_VALID);
      end
   end

   assign imem_req  = imem_req_q;
   assign imem_addr = pc_q;
   assign if_valid  = if_valid_q;
   assign if_instr  = if_instr_q;
   assign if_pc     = if_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a transaction-level model (fetch pointer, outstanding request,
// held instruction) checked every cycle, plus hand-computed literal checks along the script.
module tb_fetch_ctrl;

   localparam logic [31:0] RDX = 32'hA5A5_5A5A;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b1;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory responder: answers each granted request rv_delay cycles after the grant cycle + 1.
   int          rv_delay = 0;
   logic        ovr_en = 1'b0;
   logic [31:0] ovr_data = 32'h0;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] paddr = 32'h0;

   initial forever begin
      @(posedge clk);
      #1;
      if (pend && cnt == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ovr_en ? ovr_data : (paddr ^ RDX);
         pend        = 1'b0;
      end else begin
         imem_rvalid = 1'b0;
         if (pend) cnt--;
      end
      @(negedge clk);
      if (!reset && imem_req && imem_gnt) begin
         pend  = 1'b1;
         cnt   = rv_delay;
         paddr = imem_addr;
      end
   end

   // Model: where the fetch stream points, whether a request is in flight (and doomed),
   // and what instruction is held for decode.
   logic        m_boot = 1'b1;
   logic        m_out = 1'b0;
   logic        m_kill = 1'b0;
   logic        m_hv = 1'b0;
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_oaddr = 32'h0;
   logic [31:0] m_ifpc = 32'h0;
   logic [31:0] m_ifinstr = 32'h0;

   initial forever begin
      logic        exp_req;
      logic [31:0] tgt;
      @(negedge clk);
      if (reset) begin
         m_boot = 1'b1; m_out = 1'b0; m_kill = 1'b0; m_hv = 1'b0;
         m_pc = 32'h0; m_ifpc = 32'h0; m_ifinstr = 32'h0;
      end else begin
         exp_req = !m_boot && !m_out && !m_hv;
         tgt     = redirect_pc & 32'hFFFF_FFFC;
         chk("m_req", {31'b0, imem_req}, {31'b0, exp_req});
         if (exp_req) chk("m_addr", imem_addr, m_pc);
         chk("m_valid", {31'b0, if_valid}, {31'b0, m_hv});
         chk("m_if_pc", if_pc, m_ifpc);
         chk("m_if_instr", if_instr, m_ifinstr);
         if (m_boot) begin
            m_boot = 1'b0;
            if (redirect) m_pc = tgt;
         end else if (exp_req) begin
            if (imem_gnt) begin
               m_out = 1'b1; m_kill = redirect; m_oaddr = m_pc;
            end
            if (redirect) m_pc = tgt;
         end else if (m_out) begin
            if (imem_rvalid) begin
               m_out = 1'b0;
               if (!m_kill && !redirect) begin
                  m_hv = 1'b1; m_ifpc = m_oaddr; m_ifinstr = imem_rdata;
               end
            end else if (redirect) begin
               m_kill = 1'b1;
            end
            if (redirect) m_pc = tgt;
         end else if (m_hv) begin
            if (redirect) begin
               m_hv = 1'b0; m_pc = tgt;
            end else if (!stall) begin
               m_hv = 1'b0; m_pc = m_pc + 32'd4;
            end
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(output logic [31:0] addr, output int c);
      logic found;
      found = 1'b0;
      addr  = 32'hFFFF_FFFF;
      c     = -1;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            found = 1'b1;
            addr  = imem_addr;
            c     = cyc;
         end
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL grant_timeout: got no grant in 20 cycles expected a request");
      end
   endtask

   initial begin
      logic [31:0] a;
      int c0, c1, c2, g;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_valid", {31'b0, if_valid}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_instr", if_instr, 32'h0);
      nxt();
      reset = 1'b0;
      @(negedge clk);
      chk("boot_no_req", {31'b0, imem_req}, 32'h0);

      // Back-to-back fetch at one instruction per three cycles
      wait_grant(a, c0);
      chk("seq_addr0", a, 32'h0);
      wait_grant(a, c1);
      chk("seq_addr1", a, 32'h4);
      chk("seq_gap1", c1 - c0, 32'd3);
      wait_grant(a, c2);
      chk("seq_addr2", a, 32'h8);
      chk("seq_gap2", c2 - c1, 32'd3);

      // Stall in VALID for 4 cycles: output held for 5 cycles
      nxt();
      nxt();
      stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) nxt();
         if (i == 4) begin
            stall = 1'b0; rv_delay = 1; ovr_en = 1'b1; ovr_data = 32'hDEAD_BEEF;
         end
         @(negedge clk);
         chk("stall_valid", {31'b0, if_valid}, 32'h1);
         chk("stall_if_pc", if_pc, 32'h8);
         chk("stall_if_instr", if_instr, 32'hA5A5_5A52);
      end
      wait_grant(a, g);
      chk("stall_next_addr", a, 32'hC);
      chk("stall_next_gap", g - c2, 32'd7);

      // Redirect in WAIT before the response; the late DEADBEEF response is dropped
      nxt(); redirect = 1'b1; redirect_pc = 32'h103; rv_delay = 0;
      @(negedge clk);
      chk("rdw_valid1", {31'b0, if_valid}, 32'h0);
      chk("rdw_req1", {31'b0, imem_req}, 32'h0);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      chk("rdw_valid2", {31'b0, if_valid}, 32'h0);
      nxt(); ovr_en = 1'b0;
      @(negedge clk);
      chk("rdw_req3", {31'b0, imem_req}, 32'h1);
      chk("rdw_addr3", imem_addr, 32'h100);
      chk("rdw_valid3", {31'b0, if_valid}, 32'h0);

      // Redirect with stall while VALID
      nxt();
      nxt(); stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
      @(negedge clk);
      chk("rdv_valid", {31'b0, if_valid}, 32'h1);
      chk("rdv_if_pc", if_pc, 32'h100);
      chk("rdv_if_instr", if_instr, 32'hA5A5_5B5A);
      nxt(); stall = 1'b0; redirect = 1'b0;
      @(negedge clk);
      chk("rdv_valid_next", {31'b0, if_valid}, 32'h0);
      chk("rdv_req_next", {31'b0, imem_req}, 32'h1);
      chk("rdv_addr_next", imem_addr, 32'h40);

      // Wrap of pc+4 at the top of the address space
      nxt();
      nxt(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      chk("wrap_if_pc40", if_pc, 32'h40);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      chk("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
      nxt();
      nxt();
      @(negedge clk);
      chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_if_instr", if_instr, 32'h5A5A_A5A6);
      nxt(); imem_gnt = 1'b0;
      @(negedge clk);
      chk("wrap_addr_zero", imem_addr, 32'h0);

      // Redirect in REQ without grant, then redirect coinciding with grant
      nxt(); redirect = 1'b1; redirect_pc = 32'h202;
      @(negedge clk);
      chk("nogt_addr_stable", imem_addr, 32'h0);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      chk("nogt_addr_new", imem_addr, 32'h200);
      nxt(); imem_gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      @(negedge clk);
      chk("gtrd_addr", imem_addr, 32'h200);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      chk("gtrd_wait_req", {31'b0, imem_req}, 32'h0);
      nxt();
      @(negedge clk);
      chk("gtrd_addr_new", imem_addr, 32'h300);
      chk("gtrd_valid", {31'b0, if_valid}, 32'h0);

      // Redirect in WAIT on the same cycle as the response
      nxt(); redirect = 1'b1; redirect_pc = 32'h400; rv_delay = 1;
      @(negedge clk);
      chk("rvrd_valid", {31'b0, if_valid}, 32'h0);
      nxt(); redirect = 1'b0;
      @(negedge clk);
      chk("rvrd_addr", imem_addr, 32'h400);

      // Reset during WAIT; the response lands in BOOT and must be ignored
      nxt(); reset = 1'b1;
      @(negedge clk);
      chk("mrst_req", {31'b0, imem_req}, 32'h0);
      chk("mrst_valid", {31'b0, if_valid}, 32'h0);
      chk("mrst_addr", imem_addr, 32'h0);
      chk("mrst_if_pc", if_pc, 32'h0);
      chk("mrst_if_instr", if_instr, 32'h0);
      nxt(); reset = 1'b0; rv_delay = 0;
      @(negedge clk);
      chk("mrst_boot_req", {31'b0, imem_req}, 32'h0);
      nxt();
      @(negedge clk);
      chk("mrst_first_req", {31'b0, imem_req}, 32'h1);
      chk("mrst_first_addr", imem_addr, 32'h0);
      chk("mrst_valid_req", {31'b0, if_valid}, 32'h0);
      nxt();
      @(negedge clk);
      chk("mrst_valid_wait", {31'b0, if_valid}, 32'h0);
      nxt();
      @(negedge clk);
      chk("mrst_valid_final", {31'b0, if_valid}, 32'h1);
      chk("mrst_if_pc_final", if_pc, 32'h0);
      chk("mrst_if_instr_final", if_instr, 32'hA5A5_5A5A);

      repeat (3) nxt();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
